// File: rtl/char_mover.sv
// Per-character position engine: once per frame steps one sprite a pixel in its
// current direction, applying joystick turns and stopping at walls via tile queries.
module char_mover #(
  parameter int         START_X   = 132,
  parameter int         START_Y   = 100,
  parameter logic [1:0] START_DIR = 2'd1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_tick,
  input  logic       i_enable,
  input  logic       i_dir_valid,
  input  logic [1:0] i_dir_req,
  output logic       o_wall_req,
  output logic [5:0] o_wall_tile_x,
  output logic [4:0] o_wall_tile_y,
  input  logic       i_wall_ack,
  input  logic       i_wall_is_wall,
  output logic [9:0] o_char_x,
  output logic [9:0] o_char_y,
  output logic [1:0] o_dir,
  output logic       o_moving,
  output logic       o_busy,
  output logic       o_overrun
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CHK_REQ = 2'd1;
  localparam logic [1:0] ST_CHK_CUR = 2'd2;
  localparam logic [1:0] ST_MOVE    = 2'd3;

  localparam logic [9:0] FIELD_W = 10'd288;
  localparam logic [9:0] FIELD_H = 10'd224;

  logic [1:0] state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [1:0] dir_q, dir_d;
  logic       pendValid_q, pendValid_d;
  logic [1:0] pendDir_q, pendDir_d;
  logic       moving_q, moving_d;
  logic       overrun_q, overrun_d;
  logic [5:0] tileX_q, tileX_d;
  logic [4:0] tileY_q, tileY_d;

  logic [9:0]  xSum, ySum, cx, cy;
  logic [5:0]  centreTileX;
  logic [4:0]  centreTileY;
  logic        aligned;
  logic        pendIsReverse;
  logic        clearPend;
  logic [10:0] nbReq, nbCur;

  // Neighbour tile {col,row} of the centre tile in direction d, wrapping the maze edges.
  function automatic logic [10:0] neighbour(input logic [1:0] d, input logic [5:0] tx,
                                            input logic [4:0] ty);
    logic [5:0] nx;
    logic [4:0] ny;
    nx = tx;
    ny = ty;
    case (d)
      2'd0:    nx = (tx == 6'd35) ? 6'd0 : tx + 6'd1;
      2'd1:    nx = (tx == 6'd0) ? 6'd35 : tx - 6'd1;
      2'd2:    ny = (ty == 5'd27) ? 5'd0 : ty + 5'd1;
      default: ny = (ty == 5'd0) ? 5'd27 : ty - 5'd1;
    endcase
    return {nx, ny};
  endfunction

  always_comb begin
    xSum          = x_q + 10'd8;
    ySum          = y_q + 10'd8;
    cx            = (xSum >= FIELD_W) ? xSum - FIELD_W : xSum;
    cy            = (ySum >= FIELD_H) ? ySum - FIELD_H : ySum;
    centreTileX   = cx[8:3];
    centreTileY   = cy[7:3];
    aligned       = (x_q[2:0] == 3'd4) && (y_q[2:0] == 3'd4);
    pendIsReverse = pendValid_q && (pendDir_q == {dir_q[1], ~dir_q[0]});
    nbReq         = neighbour(pendDir_q, centreTileX, centreTileY);
    nbCur         = neighbour(dir_q, centreTileX, centreTileY);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    pendValid_d = pendValid_q;
    pendDir_d   = pendDir_q;
    moving_d    = moving_q;
    overrun_d   = overrun_q;
    tileX_d     = tileX_q;
    tileY_d     = tileY_q;
    clearPend   = 1'b0;

    if (i_frame_tick && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (i_frame_tick && i_enable) begin
          // Reversals never need a map query; other turns only happen on tile centres.
          if (pendIsReverse) begin
            dir_d     = pendDir_q;
            clearPend = 1'b1;
            state_d   = ST_MOVE;
          end else if (aligned && pendValid_q) begin
            {tileX_d, tileY_d} = nbReq;
            state_d            = ST_CHK_REQ;
          end else if (aligned) begin
            {tileX_d, tileY_d} = nbCur;
            state_d            = ST_CHK_CUR;
          end else begin
            state_d = ST_MOVE;
          end
        end
      end
      ST_CHK_REQ: begin
        if (i_wall_ack) begin
          if (!i_wall_is_wall) begin
            dir_d     = pendDir_q;
            clearPend = 1'b1;
            state_d   = ST_MOVE;
          end else begin
            {tileX_d, tileY_d} = nbCur;
            state_d            = ST_CHK_CUR;
          end
        end
      end
      ST_CHK_CUR: begin
        if (i_wall_ack) begin
          if (!i_wall_is_wall) begin
            state_d = ST_MOVE;
          end else begin
            moving_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        case (dir_q)
          2'd0:    x_d = (x_q == FIELD_W - 10'd1) ? 10'd0 : x_q + 10'd1;
          2'd1:    x_d = (x_q == 10'd0) ? FIELD_W - 10'd1 : x_q - 10'd1;
          2'd2:    y_d = (y_q == FIELD_H - 10'd1) ? 10'd0 : y_q + 10'd1;
          default: y_d = (y_q == 10'd0) ? FIELD_H - 10'd1 : y_q - 10'd1;
        endcase
        moving_d = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase

    if (clearPend) pendValid_d = 1'b0;
    // A fresh strobe overrides an apply in the same cycle; asking for the current heading cancels.
    if (i_dir_valid) begin
      if (i_dir_req == dir_d) begin
        pendValid_d = 1'b0;
      end else begin
        pendValid_d = 1'b1;
        pendDir_d   = i_dir_req;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      x_q         <= 10'(START_X);
      y_q         <= 10'(START_Y);
      dir_q       <= START_DIR;
      pendValid_q <= 1'b0;
      pendDir_q   <= 2'd0;
      moving_q    <= 1'b0;
      overrun_q   <= 1'b0;
      tileX_q     <= 6'd0;
      tileY_q     <= 5'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      pendValid_q <= pendValid_d;
      pendDir_q   <= pendDir_d;
      moving_q    <= moving_d;
      overrun_q   <= overrun_d;
      tileX_q     <= tileX_d;
      tileY_q     <= tileY_d;
    end
  end

  assign o_wall_req    = (state_q == ST_CHK_REQ) || (state_q == ST_CHK_CUR);
  assign o_wall_tile_x = tileX_q;
  assign o_wall_tile_y = tileY_q;
  assign o_char_x      = x_q;
  assign o_char_y      = y_q;
  assign o_dir         = dir_q;
  assign o_moving      = moving_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_overrun     = overrun_q;

endmodule
